tl45_muldiv_seq: RTL and testbench

Iterative multiply/divide sequencer that the TL45 execute stage issues long-latency arithmetic to. It accepts one operation at a time and holds the pipeline through a stall output while it runs. It computes one result bit per cycle with a shift-add multiplier and a restoring divider, then presents a one-cycle writeback (dest reg plus value) for the stage to forward. Pipeline flush cancels the operation in flight.

---
 rtl/tl45_muldiv_seq.sv | 122 ++++++++++++
 tb/tb_tl45_muldiv_seq.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/tl45_muldiv_seq.sv
// TL45 iterative multiply/divide sequencer: one result bit per cycle.
// Shift-add multiplier, restoring divider, single-cycle writeback pulse.
module tl45_muldiv_seq #(
  parameter int WIDTH = 32,
  parameter int DR_W  = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [DR_W-1:0]  i_dr,
  input  logic             i_flush,
  output logic             o_stall,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_result,
  output logic [DR_W-1:0]  o_dr
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [CW-1:0]      cnt;
  logic [1:0]         op;
  logic [DR_W-1:0]    dr;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH:0]     rem;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   dvsr;

  logic           accept;
  logic           div0;
  logic           last;
  logic [WIDTH:0] msum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic           fits;

  assign accept  = (state == IDLE) && i_start && !i_flush;
  assign div0    = i_op[1] && (i_b == '0);
  assign last    = (cnt == CW'(WIDTH - 1));
  assign o_stall = i_start && (state != DONE) && !i_flush;

  assign msum    = {1'b0, prod[2*WIDTH-1:WIDTH]}
                 + (prod[0] ? {1'b0, mcand} : '0);
  assign shifted = {rem[WIDTH-1:0], quo[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvsr};
  // rem[WIDTH] is never set after a restore; folding it in keeps the
  // trial compare correct for the full WIDTH+1-bit partial remainder.
  assign fits    = rem[WIDTH] || (shifted >= {1'b0, dvsr});

  always_ff @(posedge i_clk) begin
    if (i_reset) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (i_flush) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: if (i_start) state_nxt = div0 ? DONE : RUN;
        RUN:  if (last)    state_nxt = DONE;
        DONE: state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset || i_flush) cnt <= '0;
    else if (state == RUN)  cnt <= cnt + CW'(1);
    else                    cnt <= '0;
  end

  always_ff @(posedge i_clk) begin
    if (accept) begin
      op    <= i_op;
      dr    <= i_dr;
      mcand <= i_a;
      prod  <= {{WIDTH{1'b0}}, i_b};
      dvsr  <= i_b;
      quo   <= div0 ? '1 : i_a;
      rem   <= div0 ? {1'b0, i_a} : '0;
    end else if (state == RUN) begin
      if (!op[1]) begin
        prod <= {msum, prod[WIDTH-1:1]};
      end else begin
        rem <= fits ? diff : shifted;
        quo <= {quo[WIDTH-2:0], fits};
      end
    end
  end

  always_comb begin
    o_valid  = (state == DONE);
    o_dr     = '0;
    o_result = '0;
    if (state == DONE) begin
      o_dr = dr;
      unique case (op)
        2'b00: o_result = prod[WIDTH-1:0];
        2'b01: o_result = prod[2*WIDTH-1:WIDTH];
        2'b10: o_result = quo;
        2'b11: o_result = rem[WIDTH-1:0];
        default: o_result = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_tl45_muldiv_seq.sv
// Bench for tl45_muldiv_seq: vector table, random ops, flush/reset cases.
// Expected writebacks go through a queue popped by an output monitor.
module tb_tl45_muldiv_seq;

  localparam int W  = 32;
  localparam int DW = 4;

  logic          i_clk = 1'b0;
  logic          i_reset;
  logic          i_start;
  logic [1:0]    i_op;
  logic [W-1:0]  i_a;
  logic [W-1:0]  i_b;
  logic [DW-1:0] i_dr;
  logic          i_flush;
  logic          o_stall;
  logic          o_valid;
  logic [W-1:0]  o_result;
  logic [DW-1:0] o_dr;

  tl45_muldiv_seq #(.WIDTH(W), .DR_W(DW)) dut (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_start  (i_start),
    .i_op     (i_op),
    .i_a      (i_a),
    .i_b      (i_b),
    .i_dr     (i_dr),
    .i_flush  (i_flush),
    .o_stall  (o_stall),
    .o_valid  (o_valid),
    .o_result (o_result),
    .o_dr     (o_dr)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [W-1:0]  res;
    logic [DW-1:0] dr;
  } exp_t;

  typedef struct {
    logic [1:0]    op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [DW-1:0] dr;
    logic [W-1:0]  res;
    int            lat;
  } vec_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Output monitor: a valid pulse must match the oldest queued result.
  always @(negedge i_clk) begin
    if (mon_en) begin
      if (o_valid === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_valid", {32'd0, o_result}, 64'hdead);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("result", {32'd0, o_result}, {32'd0, e.res});
          chk("dr", {60'd0, o_dr}, {60'd0, e.dr});
        end
      end else begin
        chk("idle_outputs", {o_valid, o_dr, o_result},
            {1'b0, {DW{1'b0}}, {W{1'b0}}});
      end
    end
  end

  function automatic logic [W-1:0] model(input logic [1:0] op,
                                         input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    case (op)
      2'b00:   return p[W-1:0];
      2'b01:   return p[2*W-1:W];
      2'b10:   return (b == 0) ? {W{1'b1}} : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Called at posedge+1; returns at posedge+1 of the cycle after DONE
  // with i_start low, so a following call is issued back-to-back.
  task automatic do_op(input logic [1:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [DW-1:0] dr,
                       input logic [W-1:0] res, input int lat);
    int n;
    bit stall_bad;
    exp_t e;
    i_start = 1'b1;
    i_op    = op;
    i_a     = a;
    i_b     = b;
    i_dr    = dr;
    e.res   = res;
    e.dr    = dr;
    sb.push_back(e);
    n = 0;
    stall_bad = 1'b0;
    #1;
    while (o_valid !== 1'b1 && n < 100) begin
      if (o_stall !== 1'b1) stall_bad = 1'b1;
      @(posedge i_clk);
      #2;
      n++;
    end
    chk("latency", 64'(n), 64'(lat));
    chk("stall_while_busy", {63'd0, stall_bad}, 64'd0);
    chk("stall_in_done", {63'd0, o_stall}, 64'd0);
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{2'b00, 32'd7, 32'd6, 4'd3, 32'd42, 33};
    vecs[1] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd1,
                32'hFFFFFFFE, 33};
    vecs[2] = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd2,
                32'h00000001, 33};
    vecs[3] = '{2'b10, 32'd100, 32'd7, 4'd5, 32'd14, 33};
    vecs[4] = '{2'b11, 32'd100, 32'd7, 4'd6, 32'd2, 33};
    vecs[5] = '{2'b10, 32'h80000000, 32'd1, 4'd7,
                32'h80000000, 33};
    vecs[6] = '{2'b10, 32'd5, 32'd0, 4'd8, 32'hFFFFFFFF, 1};
    vecs[7] = '{2'b11, 32'd5, 32'd0, 4'd9, 32'd5, 1};

    i_reset = 1'b1;
    i_start = 1'b0;
    i_flush = 1'b0;
    i_op    = '0;
    i_a     = '0;
    i_b     = '0;
    i_dr    = '0;
    repeat (3) @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    chk("reset_valid", {63'd0, o_valid}, 64'd0);
    chk("reset_result", {32'd0, o_result}, 64'd0);
    chk("reset_dr", {60'd0, o_dr}, 64'd0);
    mon_en = 1'b1;

    for (int i = 0; i < 8; i++)
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].dr,
            vecs[i].res, vecs[i].lat);

    for (int i = 0; i < 8; i++) begin
      logic [1:0] op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = (i == 5) ? '0 : W'($urandom >> $urandom_range(0, 28));
      do_op(op, a, b, DW'(i + 1), model(op, a, b),
            (op[1] && b == 0) ? 1 : 33);
    end

    // Flush a MUL at counter==10: nothing may be written back.
    i_start = 1'b1;
    i_op    = 2'b00;
    i_a     = 32'd11;
    i_b     = 32'd13;
    i_dr    = 4'd4;
    repeat (11) @(posedge i_clk);
    #1;
    i_flush = 1'b1;
    #1;
    chk("stall_on_flush", {63'd0, o_stall}, 64'd0);
    @(posedge i_clk);
    #1;
    i_flush = 1'b0;
    i_start = 1'b0;
    repeat (40) @(posedge i_clk);
    #1;
    do_op(2'b10, 32'd9, 32'd3, 4'd10, 32'd3, 33);

    // Reset in the middle of a MUL.
    i_start = 1'b1;
    i_op    = 2'b00;
    i_a     = 32'd5;
    i_b     = 32'd5;
    i_dr    = 4'd11;
    repeat (6) @(posedge i_clk);
    #1;
    i_reset = 1'b1;
    i_start = 1'b0;
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    chk("midrun_reset_valid", {63'd0, o_valid}, 64'd0);
    chk("midrun_reset_result", {32'd0, o_result}, 64'd0);
    chk("midrun_reset_dr", {60'd0, o_dr}, 64'd0);
    repeat (40) @(posedge i_clk);
    #1;

    do_op(2'b00, 32'd3, 32'd4, 4'd12, 32'd12, 33);
    do_op(2'b10, 32'd12, 32'd4, 4'd13, 32'd3, 33);
    repeat (5) @(posedge i_clk);
    #1;
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
